// File: rtl/led_panel_rx_capture.sv
// HUB75-style panel receiver: oversamples bclk/rgb/le, deserialises each row and drains it into a frame RAM port.
// Optional statistics counters are built only when LED_RX_STATS_EN is defined.
//
// state | meaning
// IDLE  | waiting for an LE rise to snapshot a row
// DRAIN | writing the snapshot, top/bot interleaved, one pixel per clk
module led_panel_rx_capture #(
    parameter int NUM_ROW_PIXELS = 32,
    parameter int NUM_COL_PIXELS = 64,
    parameter int SYNC_STAGES    = 2,
    parameter int RAM_ADDR_W     = 16
) (
    input  logic                                 clk_in,
    input  logic                                 reset_in,
    input  logic                                 bclk_in,
    input  logic [2:0]                           rgb_top_in,
    input  logic [2:0]                           rgb_bot_in,
    input  logic [$clog2(NUM_ROW_PIXELS/2)-1:0]  addr_in,
    input  logic                                 le_in,
    input  logic                                 oe_in,
    output logic                                 ram_en_out,
    output logic                                 ram_we_out,
    output logic [RAM_ADDR_W-1:0]                ram_addr_out,
    output logic [23:0]                          ram_data_out,
    output logic                                 row_done_out,
    output logic                                 len_err_out,
    output logic                                 overrun_out,
    output logic                                 blank_out,
    output logic [15:0]                          frame_cnt_out,
    output logic [15:0]                          err_cnt_out
);
    localparam int N  = NUM_COL_PIXELS;
    localparam int AW = $clog2(NUM_ROW_PIXELS/2);
    localparam int CW = $clog2(N);
    localparam int BW = $clog2(2*N+1);
    localparam int IW = 9 + AW;
    localparam logic [RAM_ADDR_W-1:0] N_A    = RAM_ADDR_W'(N);
    localparam logic [RAM_ADDR_W-1:0] HALF_A = RAM_ADDR_W'(NUM_ROW_PIXELS/2);

    typedef enum logic {IDLE, DRAIN} state_t;

    // All pins share one synchroniser chain so rgb/addr stay aligned with bclk/le.
    logic [SYNC_STAGES-1:0][IW-1:0] sync_q;
    logic        bclk_s, le_s, oe_s, bclk_d, le_d;
    logic [2:0]  rgb_top_s, rgb_bot_s;
    logic [AW-1:0] addr_s;
    logic        bclk_rise, le_rise;

    assign {bclk_s, le_s, oe_s, rgb_top_s, rgb_bot_s, addr_s} = sync_q[SYNC_STAGES-1];
    assign bclk_rise = bclk_s & ~bclk_d;
    assign le_rise   = le_s & ~le_d;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            sync_q <= '0;
            bclk_d <= 1'b0;
            le_d   <= 1'b0;
        end else begin
            sync_q[0] <= {bclk_in, le_in, oe_in, rgb_top_in, rgb_bot_in, addr_in};
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            bclk_d <= bclk_s;
            le_d   <= le_s;
        end
    end

    logic [2:0][N-1:0] shift_top, shift_bot, shift_top_nxt, shift_bot_nxt;
    logic [BW-1:0]     bit_cnt, bit_cnt_nxt;

    // The snapshot takes the post-shift value so a coincident bclk bit is included.
    always_comb begin
        shift_top_nxt = shift_top;
        shift_bot_nxt = shift_bot;
        bit_cnt_nxt   = bit_cnt;
        if (bclk_rise) begin
            for (int k = 0; k < 3; k++) begin
                shift_top_nxt[k] = {shift_top[k][N-2:0], rgb_top_s[k]};
                shift_bot_nxt[k] = {shift_bot[k][N-2:0], rgb_bot_s[k]};
            end
            if (bit_cnt != BW'(2*N))
                bit_cnt_nxt = bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            shift_top <= '0;
            shift_bot <= '0;
            bit_cnt   <= '0;
        end else if (le_rise) begin
            shift_top <= '0;
            shift_bot <= '0;
            bit_cnt   <= '0;
        end else begin
            shift_top <= shift_top_nxt;
            shift_bot <= shift_bot_nxt;
            bit_cnt   <= bit_cnt_nxt;
        end
    end

    state_t            state;
    logic [CW-1:0]     col;
    logic              half_bot;
    logic [2:0][N-1:0] snap_top, snap_bot;
    logic [AW-1:0]     snap_addr;
    logic [2:0]        pix;
    logic [RAM_ADDR_W-1:0] addr_top, addr_bot;
    logic              snap_evt, ovr_evt, len_evt;

    assign snap_evt = le_rise && (state == IDLE);
    assign ovr_evt  = le_rise && (state == DRAIN);
    assign len_evt  = snap_evt && (bit_cnt_nxt != BW'(N));
    assign addr_top = RAM_ADDR_W'(snap_addr) * N_A + RAM_ADDR_W'(col);
    assign addr_bot = (RAM_ADDR_W'(snap_addr) + HALF_A) * N_A + RAM_ADDR_W'(col);
    assign ram_we_out = ram_en_out;

    always_comb begin
        pix = {snap_top[2][col], snap_top[1][col], snap_top[0][col]};
        if (half_bot)
            pix = {snap_bot[2][col], snap_bot[1][col], snap_bot[0][col]};
    end

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state        <= IDLE;
            col          <= '0;
            half_bot     <= 1'b0;
            snap_top     <= '0;
            snap_bot     <= '0;
            snap_addr    <= '0;
            ram_en_out   <= 1'b0;
            ram_addr_out <= '0;
            ram_data_out <= '0;
            row_done_out <= 1'b0;
            len_err_out  <= 1'b0;
            overrun_out  <= 1'b0;
            blank_out    <= 1'b0;
        end else begin
            ram_en_out   <= 1'b0;
            row_done_out <= 1'b0;
            blank_out    <= oe_s;
            if (ovr_evt)
                overrun_out <= 1'b1;
            if (len_evt)
                len_err_out <= 1'b1;
            if (snap_evt) begin
                snap_top  <= shift_top_nxt;
                snap_bot  <= shift_bot_nxt;
                snap_addr <= addr_s;
                col       <= '0;
                half_bot  <= 1'b0;
                state     <= DRAIN;
            end
            if (state == DRAIN) begin
                ram_en_out   <= 1'b1;
                ram_addr_out <= half_bot ? addr_bot : addr_top;
                ram_data_out <= {{8{pix[2]}}, {8{pix[1]}}, {8{pix[0]}}};
                half_bot     <= ~half_bot;
                if (half_bot) begin
                    if (col == CW'(N-1)) begin
                        col          <= '0;
                        state        <= IDLE;
                        row_done_out <= 1'b1;
                    end else begin
                        col <= col + 1'b1;
                    end
                end
            end
        end
    end

`ifdef LED_RX_STATS_EN
    localparam logic [AW-1:0] ADDR_MAX = '1;
    logic [AW-1:0] prev_addr;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            prev_addr     <= '0;
            frame_cnt_out <= '0;
            err_cnt_out   <= '0;
        end else begin
            if (snap_evt) begin
                prev_addr <= addr_s;
                if (addr_s == '0 && prev_addr == ADDR_MAX && frame_cnt_out != 16'hFFFF)
                    frame_cnt_out <= frame_cnt_out + 16'd1;
            end
            if ((len_evt || ovr_evt) && err_cnt_out != 16'hFFFF)
                err_cnt_out <= err_cnt_out + 16'd1;
        end
    end
`else
    assign frame_cnt_out = 16'h0;
    assign err_cnt_out   = 16'h0;
`endif

endmodule

// File: tb/tb_led_panel_rx_capture.sv
// Scoreboard bench for led_panel_rx_capture: expected RAM writes are queued, a monitor pops and compares.
module tb_led_panel_rx_capture;
    logic        clk_in = 1'b0;
    logic        reset_in, bclk_in, le_in, oe_in;
    logic [2:0]  rgb_top_in, rgb_bot_in;
    logic [3:0]  addr_in;
    logic        ram_en_out, ram_we_out, row_done_out, len_err_out, overrun_out, blank_out;
    logic [15:0] ram_addr_out, frame_cnt_out, err_cnt_out;
    logic [23:0] ram_data_out;

`ifdef LED_RX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    always #5 clk_in = ~clk_in;

    led_panel_rx_capture dut (
        .clk_in(clk_in), .reset_in(reset_in), .bclk_in(bclk_in),
        .rgb_top_in(rgb_top_in), .rgb_bot_in(rgb_bot_in), .addr_in(addr_in),
        .le_in(le_in), .oe_in(oe_in),
        .ram_en_out(ram_en_out), .ram_we_out(ram_we_out),
        .ram_addr_out(ram_addr_out), .ram_data_out(ram_data_out),
        .row_done_out(row_done_out), .len_err_out(len_err_out),
        .overrun_out(overrun_out), .blank_out(blank_out),
        .frame_cnt_out(frame_cnt_out), .err_cnt_out(err_cnt_out)
    );

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    logic [39:0] exp_q[$];
    logic [39:0] mon_exp;

    always @(negedge clk_in) begin
        if (ram_en_out) begin
            wr_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual addr=%0d data=%06h required no write",
                         ram_addr_out, ram_data_out);
            end else begin
                mon_exp = exp_q.pop_front();
                if ({ram_addr_out, ram_data_out} !== mon_exp || ram_we_out !== 1'b1) begin
                    errors++;
                    $display("FAIL ram_write actual addr=%0d data=%06h we=%0b required addr=%0d data=%06h we=1",
                             ram_addr_out, ram_data_out, ram_we_out, mon_exp[39:24], mon_exp[23:0]);
                end
            end
        end
        if (row_done_out)
            done_cnt++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [23:0] px(input logic [2:0] c);
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    task automatic bits(input int n, input logic [2:0] t, input logic [2:0] b);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_in);
            rgb_top_in = t;
            rgb_bot_in = b;
            bclk_in = 1'b0;
            repeat (3) @(negedge clk_in);
            bclk_in = 1'b1;
            repeat (4) @(negedge clk_in);
            bclk_in = 1'b0;
        end
    endtask

    task automatic latch(input logic [3:0] a);
        @(negedge clk_in);
        addr_in = a;
        repeat (2) @(negedge clk_in);
        le_in = 1'b1;
        repeat (4) @(negedge clk_in);
        le_in = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    // Columns below split carry the lo colours, columns at/above split carry hi.
    task automatic expect_row(input int a, input int split, input logic [2:0] tlo, input logic [2:0] blo,
                              input logic [2:0] thi, input logic [2:0] bhi);
        logic [2:0] t, b;
        for (int c = 0; c < 64; c++) begin
            t = (c < split) ? tlo : thi;
            b = (c < split) ? blo : bhi;
            exp_q.push_back({16'(a*64 + c), px(t)});
            exp_q.push_back({16'((a+16)*64 + c), px(b)});
        end
    endtask

    task automatic wait_drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 3000) begin
            @(negedge clk_in);
            i++;
        end
        repeat (4) @(negedge clk_in);
        chk(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        reset_in = 1'b1;
        bclk_in = 1'b0; le_in = 1'b0; oe_in = 1'b0;
        rgb_top_in = '0; rgb_bot_in = '0; addr_in = '0;
        repeat (3) @(negedge clk_in);
        exp_q.delete();
        reset_in = 1'b0;
        repeat (3) @(negedge clk_in);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0, w0;
        reset_in = 1'b1;
        bclk_in = 1'b0; le_in = 1'b0; oe_in = 1'b0;
        rgb_top_in = '0; rgb_bot_in = '0; addr_in = '0;

        // reset held while every input toggles
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_in);
            bclk_in    = 1'($urandom);
            le_in      = 1'($urandom);
            oe_in      = 1'($urandom);
            rgb_top_in = 3'($urandom);
            rgb_bot_in = 3'($urandom);
            addr_in    = 4'($urandom);
        end
        @(negedge clk_in);
        chk("rst_ram_en", ram_en_out, 0);
        chk("rst_ram_addr", ram_addr_out, 0);
        chk("rst_ram_data", ram_data_out, 0);
        chk("rst_row_done", row_done_out, 0);
        chk("rst_len_err", len_err_out, 0);
        chk("rst_overrun", overrun_out, 0);
        chk("rst_blank", blank_out, 0);
        chk("rst_frame_cnt", frame_cnt_out, 0);
        chk("rst_err_cnt", err_cnt_out, 0);
        do_reset();

        // full row, addr 3
        d0 = done_cnt;
        bits(64, 3'b100, 3'b001);
        expect_row(3, 64, 3'b100, 3'b001, 3'b000, 3'b000);
        latch(4'd3);
        wait_drain("t2_drain");
        chk("t2_row_done", done_cnt - d0, 1);
        chk("t2_len_err", len_err_out, 0);
        chk("t2_overrun", overrun_out, 0);

        oe_in = 1'b1;
        repeat (5) @(negedge clk_in);
        chk("blank_hi", blank_out, 1);
        oe_in = 1'b0;
        repeat (5) @(negedge clk_in);
        chk("blank_lo", blank_out, 0);

        // first bit after a latch lands in column 63
        bits(1, 3'b010, 3'b000);
        bits(63, 3'b000, 3'b110);
        expect_row(7, 63, 3'b000, 3'b110, 3'b010, 3'b000);
        latch(4'd7);
        wait_drain("col63_drain");
        chk("col63_len_err", len_err_out, 0);

        // short row: high columns stay black
        bits(60, 3'b011, 3'b101);
        expect_row(10, 60, 3'b011, 3'b101, 3'b000, 3'b000);
        latch(4'd10);
        wait_drain("t3_drain");
        chk("t3_len_err", len_err_out, 1);
        chk("t3_overrun", overrun_out, 0);

        // long row: only the last 64 bits survive
        bits(6, 3'b111, 3'b111);
        bits(64, 3'b010, 3'b100);
        expect_row(2, 64, 3'b010, 3'b100, 3'b000, 3'b000);
        latch(4'd2);
        wait_drain("long_drain");
        chk("long_len_err_sticky", len_err_out, 1);

        // overrun: second LE lands while the first row drains
        do_reset();
        d0 = done_cnt;
        w0 = wr_cnt;
        bits(64, 3'b110, 3'b011);
        expect_row(5, 64, 3'b110, 3'b011, 3'b000, 3'b000);
        latch(4'd5);
        bits(10, 3'b111, 3'b111);
        latch(4'd6);
        wait_drain("t4_drain");
        repeat (150) @(negedge clk_in);
        chk("t4_overrun", overrun_out, 1);
        chk("t4_writes", wr_cnt - w0, 128);
        chk("t4_row_done", done_cnt - d0, 1);

        // reset mid-drain
        do_reset();
        bits(64, 3'b001, 3'b010);
        expect_row(1, 64, 3'b001, 3'b010, 3'b000, 3'b000);
        w0 = wr_cnt;
        latch(4'd1);
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_in);
            #1;
            if (wr_cnt - w0 >= 40) break;
        end
        chk("t5_writes_before_rst", wr_cnt - w0, 40);
        reset_in = 1'b1;
        #1;
        chk("t5_en_async_clear", ram_en_out, 0);
        chk("t5_pending", exp_q.size(), 88);
        exp_q.delete();
        repeat (3) @(negedge clk_in);
        reset_in = 1'b0;
        w0 = wr_cnt;
        repeat (300) @(negedge clk_in);
        chk("t5_no_writes_after", wr_cnt - w0, 0);
        chk("t5_row_done_none", row_done_out, 0);

        // stats: addresses 0..15 then 0, then one short row
        do_reset();
        for (int a = 0; a < 17; a++) begin
            bits(64, 3'b001, 3'b000);
            expect_row(a % 16, 64, 3'b001, 3'b000, 3'b000, 3'b000);
            latch(4'(a % 16));
            wait_drain("t6_drain");
        end
        chk("t6_frame_cnt", frame_cnt_out, STATS ? 32'd1 : 32'd0);
        chk("t6_err_cnt_clean", err_cnt_out, 0);
        bits(60, 3'b100, 3'b100);
        expect_row(4, 60, 3'b100, 3'b100, 3'b000, 3'b000);
        latch(4'd4);
        wait_drain("t6_short_drain");
        chk("t6_err_cnt", err_cnt_out, STATS ? 32'd1 : 32'd0);
        chk("t6_len_err", len_err_out, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
